// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_LUI, S_JAL, S_TRAP
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCB_B     = 2'd0;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;

  // Wide enough for the largest supported timeout (255).
  localparam int WAIT_W = 8;

  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  // Returns {legal, alu_op} for an R-type funct7/funct3 pair.
  function automatic logic [3:0] r_type_op(input logic [6:0] f7, input logic [2:0] f3);
    case ({f7, f3})
      {7'b0000000, 3'b000}: return {1'b1, ALU_ADD};
      {7'b0100000, 3'b000}: return {1'b1, ALU_SUB};
      {7'b0000000, 3'b111}: return {1'b1, ALU_AND};
      {7'b0000000, 3'b010}: return {1'b1, ALU_SLT};
      default:              return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller and its datapath.
interface rv_multicycle_ctrl_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
);
  logic [31:0]        instr;
  logic               alu_zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               addr_sel;
  logic               pc_write;
  logic               pc_src;
  logic               ir_write;
  logic               load_oldpc;
  logic               load_a;
  logic               load_b;
  logic               load_aluout;
  logic               load_mdr;
  logic               reg_write;
  logic [1:0]         wb_sel;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               instr_done;
  logic [CNT_W-1:0]   instret;
  logic               trap;
  logic               timeout_err;
  logic [3:0]         state_dbg;

  modport master (
    input  instr, alu_zero, mem_ready,
    output mem_req, mem_we, addr_sel, pc_write, pc_src, ir_write, load_oldpc,
           load_a, load_b, load_aluout, load_mdr, reg_write, wb_sel,
           alu_src_a, alu_src_b, alu_op, instr_done, instret, trap,
           timeout_err, state_dbg
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  mem_req, mem_we, addr_sel, pc_write, pc_src, ir_write, load_oldpc,
           load_a, load_b, load_aluout, load_mdr, reg_write, wb_sel,
           alu_src_a, alu_src_b, alu_op, instr_done, instret, trap,
           timeout_err, state_dbg
  );
endinterface

// File: rtl/rv_multicycle_ctrl_wait_timer.sv
// Memory wait counter: counts stalled cycles of the current access and flags
// the cycle on which the stall limit is reached without mem_ready.
module rv_mem_wait_timer
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              stalled;

  assign stalled = active_i && !ready_i;

  // Held at zero outside an access and on completion, so every access starts fresh.
  assign cnt_d     = stalled ? cnt_q + WAIT_W'(1) : '0;
  assign timeout_o = stalled && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: sequencing, memory handshake
// with timeout, illegal-opcode trap and retired-instruction counter.
//
// state    | meaning
// RESET    | leaving reset, outputs idle
// FETCH    | read instruction at PC, PC += 4 on completion
// DECODE   | latch rs1/rs2, precompute branch/JAL target
// EXEC_R   | R-type ALU op
// EXEC_I   | addi
// ADDR     | load/store effective address
// MEM_RD   | load data access
// MEM_WR   | store data access, retires
// WB_ALU   | write ALUOut to rd, retires
// WB_MEM   | write MDR to rd, retires
// BRANCH   | compare rs1/rs2, conditionally take target, retires
// LUI      | pass immediate through ALU
// JAL      | link and jump, retires
// TRAP     | halted until reset
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst,
  rv_multicycle_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             timeout_err_q;

  logic       timeout, wait_active, timeout_hit;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [3:0] r_dec;
  logic       unused_instr;

  logic       mem_req, mem_we, addr_sel, pc_write, pc_src, ir_write, load_oldpc;
  logic       load_a, load_b, load_aluout, load_mdr, reg_write, instr_done, trap;
  logic [1:0] wb_sel, alu_src_a, alu_src_b;
  logic [2:0] alu_op;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign funct7       = bus.instr[31:25];
  assign r_dec        = r_type_op(funct7, funct3);
  assign unused_instr = ^{bus.instr[24:15], bus.instr[11:7]};
  assign wait_active  = is_mem_wait(state_q);

  rv_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .active_i  (wait_active),
    .ready_i   (bus.mem_ready),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ir_write    = 1'b0;
    load_oldpc  = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    load_aluout = 1'b0;
    load_mdr    = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    trap        = 1'b0;
    timeout_hit = 1'b0;
    wb_sel      = WB_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    alu_op      = ALU_PASSA;

    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        alu_op    = ALU_ADD;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          load_oldpc = 1'b1;
          pc_write   = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          timeout_hit = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_DECODE: begin
        load_a      = 1'b1;
        load_b      = 1'b1;
        load_aluout = 1'b1;
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        alu_op      = ALU_ADD;
        case (opcode)
          OPC_OP:              state_d = S_EXEC_R;
          OPC_OP_IMM:          state_d = S_EXEC_I;
          OPC_LOAD, OPC_STORE: state_d = S_ADDR;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_LUI:             state_d = S_LUI;
          OPC_JAL:             state_d = S_JAL;
          default:             state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_B;
        load_aluout = 1'b1;
        if (r_dec[3]) begin
          alu_op  = r_dec[2:0];
          state_d = S_WB_ALU;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_op      = ALU_ADD;
        load_aluout = 1'b1;
        state_d     = (funct3 == 3'b000) ? S_WB_ALU : S_TRAP;
      end
      S_ADDR: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_op      = ALU_ADD;
        load_aluout = 1'b1;
        if (funct3 != 3'b010)        state_d = S_TRAP;
        else if (opcode == OPC_STORE) state_d = S_MEM_WR;
        else                          state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready) begin
          load_mdr = 1'b1;
          state_d  = S_WB_MEM;
        end else if (timeout) begin
          timeout_hit = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          timeout_hit = 1'b1;
          state_d     = S_TRAP;
        end
      end
      S_WB_ALU: begin
        reg_write  = 1'b1;
        wb_sel     = WB_ALUOUT;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        wb_sel     = WB_MDR;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        case (funct3)
          3'b000: begin
            pc_write   = bus.alu_zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          3'b001: begin
            pc_write   = !bus.alu_zero;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_LUI: begin
        alu_src_b   = SRCB_IMM;
        alu_op      = ALU_PASSB;
        load_aluout = 1'b1;
        state_d     = S_WB_ALU;
      end
      // PC already advanced to PC+4 in FETCH, so it is the link value.
      S_JAL: begin
        reg_write  = 1'b1;
        wb_sel     = WB_PC;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RESET;
      instret_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (instr_done)  instret_q     <= instret_q + CNT_W'(1);
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.addr_sel    = addr_sel;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.ir_write    = ir_write;
  assign bus.load_oldpc  = load_oldpc;
  assign bus.load_a      = load_a;
  assign bus.load_b      = load_b;
  assign bus.load_aluout = load_aluout;
  assign bus.load_mdr    = load_mdr;
  assign bus.reg_write   = reg_write;
  assign bus.wb_sel      = wb_sel;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_op      = ALUOP_W'(alu_op);
  assign bus.instr_done  = instr_done;
  assign bus.instret     = instret_q;
  assign bus.trap        = trap;
  assign bus.timeout_err = timeout_err_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench: a per-instruction model expands each instruction into
// its expected cycle sequence and output pattern, compared every cycle.
module tb_rv_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC_R = 4'd3, ST_EXEC_I = 4'd4, ST_ADDR = 4'd5;
  localparam logic [3:0] ST_MEM_RD = 4'd6, ST_MEM_WR = 4'd7, ST_WB_ALU = 4'd8;
  localparam logic [3:0] ST_WB_MEM = 4'd9, ST_BRANCH = 4'd10, ST_LUI = 4'd11;
  localparam logic [3:0] ST_JAL = 4'd12,   ST_TRAP = 4'd13;

  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h40208133;
  localparam logic [31:0] I_AND = 32'h0020F1B3, I_SLT = 32'h0020A1B3;
  localparam logic [31:0] I_MUL = 32'h022081B3, I_ADDI = 32'h00108093;
  localparam logic [31:0] I_SLLI = 32'h00109093, I_LW = 32'h0000A183;
  localparam logic [31:0] I_LB = 32'h00008183, I_SW = 32'h0020A023;
  localparam logic [31:0] I_SH = 32'h00209023, I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BNE = 32'h00209463, I_BLT = 32'h0020C463;
  localparam logic [31:0] I_LUI = 32'h123450B7, I_JAL = 32'h008000EF;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_instret = '0;

  rv_multicycle_ctrl_if #(.ALUOP_W(3), .CNT_W(32)) bus ();

  rv_multicycle_ctrl #(.ALUOP_W(3), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    bit         waits;
    bit         rdy;
  } cyc_t;

  cyc_t exp_q[$];
  bit   exp_trap, exp_tmo;

  function automatic void push(input logic [3:0] st);
    cyc_t c;
    c.st = st; c.waits = 1'b0; c.rdy = 1'b0;
    exp_q.push_back(c);
  endfunction

  // A memory phase lasts w stall cycles plus the completing one, unless the
  // stall limit is hit first, in which case it ends in a timeout trap.
  function automatic bit push_wait(input logic [3:0] st, input int w);
    bit done;
    int n;
    done = (w < MEM_TIMEOUT);
    n    = done ? w + 1 : MEM_TIMEOUT;
    for (int i = 0; i < n; i++) begin
      cyc_t c;
      c.st = st; c.waits = 1'b1; c.rdy = done && (i == n - 1);
      exp_q.push_back(c);
    end
    if (!done) begin exp_trap = 1'b1; exp_tmo = 1'b1; end
    return done;
  endfunction

  function automatic bit r_legal(input logic [31:0] ins, output logic [2:0] op);
    op = 3'd0;
    case ({ins[31:25], ins[14:12]})
      10'b0000000_000: begin op = 3'b001; return 1'b1; end
      10'b0100000_000: begin op = 3'b010; return 1'b1; end
      10'b0000000_111: begin op = 3'b011; return 1'b1; end
      10'b0000000_010: begin op = 3'b111; return 1'b1; end
      default:         return 1'b0;
    endcase
  endfunction

  function automatic void build(input logic [31:0] ins, input int fw, input int mw);
    logic [2:0] op, f3;
    f3 = ins[14:12];
    exp_q.delete();
    exp_trap = 1'b0;
    exp_tmo  = 1'b0;
    if (!push_wait(ST_FETCH, fw)) return;
    push(ST_DECODE);
    case (ins[6:0])
      7'b0110011: begin
        push(ST_EXEC_R);
        if (r_legal(ins, op)) push(ST_WB_ALU); else exp_trap = 1'b1;
      end
      7'b0010011: begin
        push(ST_EXEC_I);
        if (f3 == 3'b000) push(ST_WB_ALU); else exp_trap = 1'b1;
      end
      7'b0000011, 7'b0100011: begin
        push(ST_ADDR);
        if (f3 != 3'b010) exp_trap = 1'b1;
        else if (ins[6:0] == 7'b0100011) void'(push_wait(ST_MEM_WR, mw));
        else if (push_wait(ST_MEM_RD, mw)) push(ST_WB_MEM);
      end
      7'b1100011: begin
        push(ST_BRANCH);
        if (f3 > 3'b001) exp_trap = 1'b1;
      end
      7'b0110111: begin push(ST_LUI); push(ST_WB_ALU); end
      7'b1101111: push(ST_JAL);
      default:    exp_trap = 1'b1;
    endcase
  endfunction

  // {state, instr_done, reg_write, mem_req, ir_write, load_mdr, pc_write, wb_sel}
  function automatic logic [11:0] expect_vec(input cyc_t c, input logic [2:0] f3,
                                             input bit zero, input bit last);
    logic rw, mr, irw, lm, pw;
    logic [1:0] wb;
    rw  = (c.st == ST_WB_ALU) || (c.st == ST_WB_MEM) || (c.st == ST_JAL);
    mr  = (c.st == ST_FETCH) || (c.st == ST_MEM_RD) || (c.st == ST_MEM_WR);
    irw = (c.st == ST_FETCH) && c.rdy;
    lm  = (c.st == ST_MEM_RD) && c.rdy;
    pw  = irw || (c.st == ST_JAL) ||
          ((c.st == ST_BRANCH) && (((f3 == 3'b000) && zero) || ((f3 == 3'b001) && !zero)));
    wb  = (c.st == ST_WB_MEM) ? 2'd1 : (c.st == ST_JAL) ? 2'd2 : 2'd0;
    return {c.st, last, rw, mr, irw, lm, pw, wb};
  endfunction

  function automatic logic [27:0] all_outs();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.pc_write, bus.pc_src,
            bus.ir_write, bus.load_oldpc, bus.load_a, bus.load_b, bus.load_aluout,
            bus.load_mdr, bus.reg_write, bus.wb_sel, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.instr_done, bus.trap, bus.timeout_err, bus.state_dbg};
  endfunction

  // Called at posedge+1 with the DUT in FETCH.
  task automatic exec_instr(input logic [31:0] ins, input int fw, input int mw,
                            input bit zero, input string name);
    logic [11:0] expv, got;
    logic [2:0]  op;
    bit          rl, last;
    build(ins, fw, mw);
    rl = r_legal(ins, op);
    bus.instr    = ins;
    bus.alu_zero = zero;
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = exp_q[i].waits ? exp_q[i].rdy : 1'($urandom_range(0, 1));
      #2;
      last = (i == exp_q.size() - 1) && !exp_trap;
      expv = expect_vec(exp_q[i], ins[14:12], zero, last);
      got  = {bus.state_dbg, bus.instr_done, bus.reg_write, bus.mem_req, bus.ir_write,
              bus.load_mdr, bus.pc_write, bus.wb_sel};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d outputs: got %h expected %h", name, i, got, expv);
      end
      if (exp_q[i].st == ST_EXEC_R && rl) begin
        checks++;
        if (bus.alu_op !== op) begin
          errors++;
          $display("FAIL %s alu_op: got %0d expected %0d", name, bus.alu_op, op);
        end
      end
      if (exp_q[i].st == ST_BRANCH) begin
        checks++;
        if ({bus.pc_src, bus.alu_op} !== 4'b1_010) begin
          errors++;
          $display("FAIL %s branch pc_src/alu_op: got %b expected 1010", name,
                   {bus.pc_src, bus.alu_op});
        end
      end
      @(posedge clk); #1;
    end
    #2;
    checks++;
    if (exp_trap) begin
      if ({bus.state_dbg, bus.trap, bus.timeout_err, bus.instr_done, bus.instret} !==
          {ST_TRAP, 1'b1, exp_tmo, 1'b0, exp_instret}) begin
        errors++;
        $display("FAIL %s trap: got st=%0d trap=%b tmo=%b instret=%0d expected st=13 trap=1 tmo=%b instret=%0d",
                 name, bus.state_dbg, bus.trap, bus.timeout_err, bus.instret, exp_tmo, exp_instret);
      end
    end else begin
      exp_instret++;
      if (bus.state_dbg !== ST_FETCH || bus.instret !== exp_instret || bus.timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL %s retire: got st=%0d instret=%0d tmo=%b expected st=1 instret=%0d tmo=0",
                 name, bus.state_dbg, bus.instret, bus.timeout_err, exp_instret);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.instr = I_ADD; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
    rst = 1'b1;
    #3;
    checks++;
    if (all_outs() !== '0 || bus.instret !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h instret %0d expected all zero", all_outs(), bus.instret);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.state_dbg !== ST_FETCH) begin
      errors++;
      $display("FAIL reset release state: got %0d expected %0d", bus.state_dbg, ST_FETCH);
    end
  endtask

  task automatic test_add();
    exec_instr(I_ADD, 0, 0, 1'b0, "add");
  endtask

  task automatic test_load();
    exec_instr(I_LW, 3, 2, 1'b0, "lw_wait");
    exec_instr(I_LW, 0, 0, 1'b1, "lw");
    exec_instr(I_SW, 1, 4, 1'b0, "sw");
  endtask

  task automatic test_branch();
    exec_instr(I_BEQ, 0, 0, 1'b1, "beq_taken");
    exec_instr(I_BEQ, 0, 0, 1'b0, "beq_not");
    exec_instr(I_BNE, 0, 0, 1'b1, "bne_not");
    exec_instr(I_BNE, 0, 0, 1'b0, "bne_taken");
    exec_instr(I_LUI, 0, 0, 1'b0, "lui");
    exec_instr(I_JAL, 0, 0, 1'b0, "jal");
  endtask

  task automatic test_illegal();
    exec_instr(I_BAD, 0, 0, 1'b0, "illegal");
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (bus.trap !== 1'b1 || bus.instret !== exp_instret || bus.state_dbg !== ST_TRAP ||
          {bus.mem_req, bus.pc_write, bus.ir_write, bus.reg_write, bus.instr_done} !== 5'b0) begin
        errors++;
        $display("FAIL trap hold %0d: got trap=%b st=%0d instret=%0d expected trap=1 st=13 instret=%0d",
                 i, bus.trap, bus.state_dbg, bus.instret, exp_instret);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.trap !== 1'b0 || bus.state_dbg !== ST_RESET) begin
      errors++;
      $display("FAIL trap clear: got trap=%b st=%0d expected trap=0 st=0", bus.trap, bus.state_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    @(posedge clk); #1;
    exec_instr(I_MUL, 0, 0, 1'b0, "bad_funct7");
    do_reset();
    exec_instr(I_BLT, 0, 0, 1'b0, "bad_branch");
    do_reset();
  endtask

  task automatic test_timeout();
    exec_instr(I_SW, 0, MEM_TIMEOUT, 1'b0, "sw_timeout");
    do_reset();
    exec_instr(I_SW, 0, MEM_TIMEOUT - 1, 1'b0, "sw_last_cycle");
    exec_instr(I_LW, MEM_TIMEOUT - 1, MEM_TIMEOUT - 1, 1'b0, "lw_last_cycle");
    exec_instr(I_ADD, MEM_TIMEOUT + 3, 0, 1'b0, "fetch_timeout");
    do_reset();
    exec_instr(I_LW, 0, MEM_TIMEOUT, 1'b0, "lw_timeout");
    do_reset();
  endtask

  task automatic test_reset_mid();
    bus.instr = I_LW; bus.alu_zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_ready = 1'b0;
    #2;
    checks++;
    if (bus.state_dbg !== ST_MEM_RD || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid reset setup: got st=%0d req=%b expected st=6 req=1", bus.state_dbg, bus.mem_req);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0 || bus.instret !== '0) begin
      errors++;
      $display("FAIL mid reset outputs: got %h instret %0d expected all zero", all_outs(), bus.instret);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_instret = '0;
    @(posedge clk); #1;
    checks++;
    if (bus.state_dbg !== ST_FETCH) begin
      errors++;
      $display("FAIL mid reset release: got st=%0d expected 1", bus.state_dbg);
    end
  endtask

  task automatic test_random();
    logic [31:0] tbl [19];
    tbl = '{I_ADD, I_SUB, I_AND, I_SLT, I_MUL, I_ADDI, I_SLLI, I_LW, I_LB, I_SW,
            I_SH, I_BEQ, I_BNE, I_BLT, I_LUI, I_JAL, I_BAD, I_ADD, I_LW};
    for (int n = 0; n < 60; n++) begin
      exec_instr(tbl[$urandom_range(0, 18)], $urandom_range(0, 5), $urandom_range(0, 5),
                 1'($urandom_range(0, 1)), "random");
      if (exp_trap) do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.instr = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Parametrised control FSM for the multicycle RV32I datapath. It drives the PC, IR, A/B, ALUOut, MDR and register-file enables, the datapath mux selects and the ALU opcode. It supports variable-latency memory through a req/ready handshake with a timeout, traps illegal opcodes, and counts retired instructions. It sits beside the datapath; its `instr` input comes from the instruction register output.

Parameters:
ALUOP_W, 3, width of alu_op (min 3)
MEM_TIMEOUT, 15, max cycles waiting on mem_ready before trapping (1..255)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr  in  32  current IR contents
alu_zero  in  1  ALU result == 0
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write (store)
addr_sel  out  1  memory address: 0 = PC, 1 = ALUOut
pc_write  out  1  PC load enable
pc_src  out  1  PC input: 0 = ALU result, 1 = ALUOut
ir_write  out  1  IR load enable
load_oldpc  out  1  latch PC into OldPC
load_a  out  1  latch rs1 into A
load_b  out  1  latch rs2 into B
load_aluout  out  1  latch ALU result
load_mdr  out  1  latch memory read data
reg_write  out  1  register-file write
wb_sel  out  2  writeback source: 0 = ALUOut, 1 = MDR, 2 = PC
alu_src_a  out  2  ALU A input: 0 = PC, 1 = A, 2 = OldPC
alu_src_b  out  2  ALU B input: 0 = B, 1 = const 4, 2 = immediate
alu_op  out  ALUOP_W  ALU operation
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
instret  out  CNT_W  retired-instruction count
trap  out  1  sticky; FSM halted in TRAP
timeout_err  out  1  sticky; trap was caused by a memory timeout
state_dbg  out  4  current state encoding

Behaviour:
- Reset, asynchronous: state = RESET; all outputs 0; instret = 0; wait counter = 0.
- Any output not listed for a state is 0.
- RESET -> FETCH unconditionally.
- FETCH:
  - mem_req = 1, addr_sel = 0, alu_src_a = 0, alu_src_b = 1, alu_op = ADD.
  - When mem_ready = 1 (Mealy, same cycle): ir_write, load_oldpc, pc_write (pc_src = 0) all 1; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: load_a, load_b, load_aluout = 1; alu_src_a = 2, alu_src_b = 2, alu_op = ADD (branch/JAL target). Next state by instr[6:0]:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 0110111 -> LUI
  - 1101111 -> JAL
  - any other opcode -> TRAP
- EXEC_R: alu_src_a = 1, alu_src_b = 0, load_aluout = 1. alu_op from {funct7, funct3}:
  - 0000000/000 ADD; 0100000/000 SUB; 0000000/111 AND; 0000000/010 SLT.
  - Any other combination -> TRAP.
  - Otherwise next state WB_ALU.
- EXEC_I: funct3 = 000 (addi) required, else TRAP. alu_src_a = 1, alu_src_b = 2, ADD, load_aluout = 1; next WB_ALU.
- ADDR: funct3 = 010 required, else TRAP. alu_src_a = 1, alu_src_b = 2, ADD, load_aluout = 1; next MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req = 1, addr_sel = 1; on mem_ready: load_mdr = 1, next WB_MEM.
- MEM_WR: mem_req = 1, mem_we = 1, addr_sel = 1; on mem_ready: instr_done = 1, next FETCH.
- WB_ALU / WB_MEM: reg_write = 1, wb_sel = 0 or 1 respectively, instr_done = 1; next FETCH.
- BRANCH:
  - alu_src_a = 1, alu_src_b = 0, alu_op = SUB, pc_src = 1.
  - pc_write = alu_zero for funct3 000 (beq), = !alu_zero for 001 (bne); other funct3 -> TRAP.
  - instr_done = 1; next FETCH.
- LUI: alu_src_b = 2, alu_op = PASSB, load_aluout = 1; next WB_ALU.
- JAL: reg_write = 1, wb_sel = 2 (PC already holds PC+4), pc_write = 1, pc_src = 1, instr_done = 1; next FETCH.
- TRAP: trap = 1, all enables 0, stays until rst. instr_done is not pulsed.
- Wait counter:
  - Cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready = 0 in those states.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 -> TRAP and timeout_err = 1.
  - mem_ready on the same cycle the count would reach MEM_TIMEOUT wins (access completes).
- instret increments on each instr_done and wraps modulo 2^CNT_W.
- Zero-wait latencies (cycles):
  - R/addi/lui: 4
  - lw: 5
  - sw: 4
  - beq/bne/jal: 3
- Reset mid-access: mem_req drops asynchronously; no partial writeback.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum: RESET, FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, LUI, JAL, TRAP; 4-bit encoding in that order, 0..13.
  - Opcode constants.
  - alu_op constants: PASSA 000, ADD 001, SUB 010, AND 011, PASSB 100, SLT 111.
  - wb_sel / alu_src encodings.
- One sub-module, rv_mem_wait_timer: wait counter plus timeout compare, parametrised by MEM_TIMEOUT.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, WB_ALU; reg_write = 1 cycle 4, alu_op = 001 in EXEC_R; instret = 1.
- lw (0x0000A183), mem_ready delayed 3 cycles in FETCH and 2 in MEM_RD -> total 10 cycles; load_mdr one cycle; wb_sel = 1; timeout_err = 0.
- beq (0x00208463) with alu_zero = 1 -> pc_write = 1, pc_src = 1 in BRANCH; with alu_zero = 0 -> pc_write = 0; bne (0x00209463) gives the inverse.
- Opcode 0x0000007F -> TRAP after DECODE; trap = 1 held 20 cycles; instret unchanged; rst clears trap.
- MEM_TIMEOUT = 15, mem_ready held 0 in MEM_WR -> TRAP at 15th wait cycle, timeout_err = 1; repeat with mem_ready at 15th cycle -> completes, no trap.
- Assert rst asynchronously mid MEM_RD -> all outputs 0 immediately, state_dbg = 0; FETCH one cycle after release.
